// File: rtl/ula_datapath.sv
// Register/ALU datapath executing the load / add / shift / store step sequence
// on X, Y and Z, with a sequence tracker that rejects out-of-order step codes.
module ula_datapath #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [2:0]   count,
    input  logic [W-1:0] val,
    output logic [W-1:0] x_q,
    output logic [W-1:0] y_q,
    output logic [W-1:0] z_q,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         carry,
    output logic         seq_err
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'b000,
        S_OPND  = 3'b001,
        S_ADD   = 3'b010,
        S_SHIFT = 3'b011,
        S_STORE = 3'b100
    } step_t;

    step_t        exp_reg, exp_next;
    logic [W-1:0] x_reg, x_next;
    logic [W-1:0] y_reg, y_next;
    logic [W-1:0] z_reg, z_next;
    logic         carry_reg, carry_next;
    logic         err_reg, err_next;
    logic         valid_reg, valid_next;
    logic [W:0]   sum;
    logic         accept;

    assign sum    = {1'b0, x_reg} + {1'b0, y_reg};
    // Codes 101..111 can never equal exp_reg, so they always fall through to reject.
    assign accept = en && ((count == S_LOAD) || (count == exp_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_reg   <= S_LOAD;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            carry_reg <= 1'b0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            exp_reg   <= exp_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            carry_reg <= carry_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        exp_next   = exp_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        carry_next = carry_reg;
        err_next   = err_reg;
        valid_next = 1'b0;
        if (accept) begin
            case (count)
                3'b000: begin
                    x_next     = val;
                    y_next     = '0;
                    carry_next = 1'b0;
                    err_next   = 1'b0;
                    exp_next   = S_OPND;
                end
                3'b001: begin
                    y_next   = val;
                    exp_next = S_ADD;
                end
                3'b010: begin
                    {carry_next, y_next} = sum;
                    exp_next             = S_SHIFT;
                end
                3'b011: begin
                    y_next     = {carry_reg, y_reg[W-1:1]};
                    carry_next = 1'b0;
                    exp_next   = S_STORE;
                end
                3'b100: begin
                    z_next     = y_reg;
                    x_next     = '0;
                    y_next     = '0;
                    valid_next = 1'b1;
                    exp_next   = S_LOAD;
                end
                default: begin
                end
            endcase
        end else if (en) begin
            err_next = 1'b1;
        end
    end

    assign x_q          = x_reg;
    assign y_q          = y_reg;
    assign z_q          = z_reg;
    assign result       = z_reg;
    assign result_valid = valid_reg;
    assign carry        = carry_reg;
    assign seq_err      = err_reg;

endmodule

// File: tb/tb_ula_datapath.sv
// Scoreboard bench for ula_datapath: a per-cycle expected-state queue and a
// result queue, both filled by a behavioural model and drained by monitors.
module tb_ula_datapath;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [2:0]   count;
    logic [W-1:0] val;
    logic [W-1:0] x_q, y_q, z_q, result;
    logic         result_valid, carry, seq_err;

    ula_datapath #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .count(count), .val(val),
        .x_q(x_q), .y_q(y_q), .z_q(z_q), .result(result),
        .result_valid(result_valid), .carry(carry), .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int z;
        int c;
        int err;
        int vld;
    } snap_t;

    snap_t sq[$];
    int    rq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Behavioural model state
    int m_x, m_y, m_z, m_c, m_err, m_vld, m_exp;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_z = 0; m_c = 0; m_err = 0; m_vld = 0; m_exp = 0;
    endtask

    task automatic model_step(input bit e, input int code, input int v);
        int s;
        m_vld = 0;
        if (e) begin
            if (code == 0 || code == m_exp) begin
                case (code)
                    0: begin m_x = v; m_y = 0; m_c = 0; m_err = 0; m_exp = 1; end
                    1: begin m_y = v; m_exp = 2; end
                    2: begin
                        s   = m_x + m_y;
                        m_y = s & MASK;
                        m_c = s >> W;
                        m_exp = 3;
                    end
                    3: begin
                        m_y = (m_c << (W - 1)) + (m_y / 2);
                        m_c = 0;
                        m_exp = 4;
                    end
                    default: begin
                        m_z = m_y; m_x = 0; m_y = 0; m_vld = 1; m_exp = 0;
                    end
                endcase
            end else begin
                m_err = 1;
            end
        end
    endtask

    // One clock cycle: drive at negedge, model, push expectations, return after the edge.
    task automatic step(input bit e, input int code, input int v);
        snap_t s;
        @(negedge clk);
        en    = e;
        count = 3'(code);
        val   = W'(v);
        model_step(e, code, v);
        s = '{x: m_x, y: m_y, z: m_z, c: m_c, err: m_err, vld: m_vld};
        sq.push_back(s);
        if (m_vld != 0) rq.push_back(m_z);
        $display("step en=%0d code=%0d val=%0d -> exp x=%0d y=%0d z=%0d c=%0d err=%0d vld=%0d",
                 e, code, v, m_x, m_y, m_z, m_c, m_err, m_vld);
        @(posedge clk);
        #2;
    endtask

    task automatic nominal(input int a, input int b);
        step(1, 0, a);
        step(1, 1, b);
        step(1, 2, $urandom_range(0, MASK));
        step(1, 3, $urandom_range(0, MASK));
        step(1, 4, $urandom_range(0, MASK));
    endtask

    // Per-cycle state monitor
    always @(posedge clk) begin
        #1;
        if (sq.size() > 0) begin
            snap_t s;
            s = sq.pop_front();
            chk("x_q", int'(x_q), s.x);
            chk("y_q", int'(y_q), s.y);
            chk("z_q", int'(z_q), s.z);
            chk("carry", int'(carry), s.c);
            chk("seq_err", int'(seq_err), s.err);
            chk("result_valid", int'(result_valid), s.vld);
        end
    end

    // Result monitor: every valid pulse must match a queued result
    always @(posedge clk) begin
        #1;
        if (rst_n && result_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                chk("result", int'(result), rq.pop_front());
            end
        end
    end

    initial begin
        int code;
        rst_n = 1'b0;
        en    = 1'b0;
        count = '0;
        val   = '0;
        model_reset();
        #3;
        chk("reset_x", int'(x_q), 0);
        chk("reset_z", int'(z_q), 0);
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_err", int'(seq_err), 0);
        #9 rst_n = 1'b1;

        // Illegal codes straight after reset
        step(1, 5, 9);
        step(1, 6, 9);
        step(1, 7, 9);
        chk("illegal_err", int'(seq_err), 1);
        chk("illegal_x", int'(x_q), 0);

        // Nominal
        step(1, 0, 3);
        chk("nom_err_cleared", int'(seq_err), 0);
        step(1, 1, 5);
        step(1, 2, 77);
        chk("nom_add_y", int'(y_q), 8);
        chk("nom_add_c", int'(carry), 0);
        step(1, 3, 11);
        chk("nom_shift_y", int'(y_q), 4);
        step(1, 4, 22);
        chk("nom_z", int'(z_q), 4);
        chk("nom_valid", int'(result_valid), 1);
        step(0, 0, 0);
        chk("nom_valid_drop", int'(result_valid), 0);

        // Carry path
        step(1, 0, 200);
        step(1, 1, 100);
        step(1, 2, 0);
        chk("carry_add_y", int'(y_q), 44);
        chk("carry_add_c", int'(carry), 1);
        step(1, 3, 0);
        chk("carry_shift_y", int'(y_q), 150);
        step(1, 4, 0);
        chk("carry_z", int'(result), 150);

        // Out-of-order then recovery
        step(1, 0, 3);
        step(1, 3, 0);
        chk("ooo_err", int'(seq_err), 1);
        chk("ooo_y", int'(y_q), 0);
        step(1, 1, 5);
        chk("ooo_y_accept", int'(y_q), 5);
        chk("ooo_err_sticky", int'(seq_err), 1);
        step(1, 2, 0);
        step(1, 2, 0);
        chk("repeat_err", int'(seq_err), 1);
        step(1, 0, 1);
        chk("ooo_err_clear", int'(seq_err), 0);

        // Stall between 010 and 011
        step(1, 0, 3);
        step(1, 1, 5);
        step(1, 2, 0);
        for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 7), $urandom_range(0, MASK));
        step(1, 3, 0);
        step(1, 4, 0);
        chk("stall_z", int'(z_q), 4);

        // Restart after 010: Z held, no valid
        step(1, 0, 9);
        step(1, 1, 9);
        step(1, 2, 0);
        step(1, 0, 7);
        chk("restart_z_held", int'(z_q), 4);
        chk("restart_x", int'(x_q), 7);

        // Async reset mid-sequence after 010
        step(1, 1, 1);
        step(1, 2, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_x", int'(x_q), 0);
        chk("areset_y", int'(y_q), 0);
        chk("areset_z", int'(z_q), 0);
        chk("areset_c", int'(carry), 0);
        chk("areset_err", int'(seq_err), 0);
        rst_n = 1'b1;
        nominal(3, 5);
        chk("post_reset_z", int'(z_q), 4);

        // Randomised traffic, biased toward legal progressions
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      code = m_exp;
            else if (r < 85) code = 0;
            else             code = $urandom_range(0, 7);
            step($urandom_range(0, 9) < 8, code, $urandom_range(0, MASK));
        end

        step(0, 0, 0);
        step(0, 0, 0);
        chk("state_queue_drained", sq.size(), 0);
        chk("result_queue_drained", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
